mem_arbiter: RTL and testbench

//  Shares the single byte-wide RAM/IO port between the instruction fetcher and the LS queue.

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter between instruction fetch and the LS queue for the shared RAM/IO port.
// Assembles/splits little-endian words, stalls IO stores on a full UART buffer, aborts flushed reads.
module mem_arbiter #(
    parameter int FETCH_STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        in_clear,
    input  logic        in_fetch_req,
    input  logic [31:0] in_fetch_addr,
    output logic        out_fetch_ok,
    output logic [31:0] out_fetch_data,
    input  logic        in_ls_req,
    input  logic        in_ls_iswrite,
    input  logic [1:0]  in_ls_size,
    input  logic [31:0] in_ls_addr,
    input  logic [31:0] in_ls_data,
    output logic        out_ls_ok,
    output logic [31:0] out_ls_data,
    output logic [31:0] out_ram_addr,
    output logic        out_ram_wr,
    output logic [7:0]  out_ram_dout,
    input  logic [7:0]  in_ram_din,
    input  logic        in_io_full
);

    localparam int SW = $clog2(FETCH_STARVE_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, READ, WRITE, IO_WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   base_q, wdata_q;
    logic [2:0]    cnt_q, nbytes_q;
    logic          is_fetch_q, is_write_q;
    logic [SW-1:0] streak_q;
    logic [1:0]    mask_q;
    logic [31:0]   fetch_data_q, ls_data_q;

    logic [31:0] cur_addr, wshift;
    logic [2:0]  ls_nbytes;
    logic [1:0]  cap_idx;
    logic        io_stall, can_grant, grant_fetch, grant_ls, done_ok;

    assign cur_addr = base_q + {29'd0, cnt_q};
    assign wshift   = wdata_q >> {cnt_q[1:0], 3'b000};
    assign cap_idx  = 2'(cnt_q - 3'd1);
    assign io_stall = is_write_q && (cur_addr[17:16] == 2'b11) && in_io_full;

    always_comb begin
        unique case (in_ls_size)
            2'd0:    ls_nbytes = 3'd1;
            2'd1:    ls_nbytes = 3'd2;
            default: ls_nbytes = 3'd4;
        endcase
    end

    // The cycle after DONE is a turnaround: the served requester still shows req,
    // so nobody is granted and both requesters re-arbitrate on the following cycle.
    assign can_grant   = (state_q == IDLE) && !in_clear && (mask_q == 2'b00);
    assign grant_fetch = can_grant && in_fetch_req &&
                         (!in_ls_req || streak_q >= SW'(FETCH_STARVE_LIMIT));
    assign grant_ls    = can_grant && in_ls_req && !grant_fetch;

    // A flush landing on DONE kills a read's ok pulse; committed stores always report.
    assign done_ok        = (state_q == DONE) && (is_write_q || !in_clear);
    assign out_fetch_ok   = done_ok && is_fetch_q;
    assign out_ls_ok      = done_ok && !is_fetch_q;
    assign out_fetch_data = fetch_data_q;
    assign out_ls_data    = ls_data_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no latch is inferred.
        state_d      = state_q;
        out_ram_addr = 32'd0;
        out_ram_wr   = 1'b0;
        out_ram_dout = 8'd0;
        unique case (state_q)
            IDLE: begin
                if (grant_fetch || grant_ls)
                    state_d = (grant_ls && in_ls_iswrite) ? WRITE : READ;
            end
            READ: begin
                if (cnt_q < nbytes_q)
                    out_ram_addr = cur_addr;
                if (in_clear)
                    state_d = IDLE;
                else if (cnt_q == nbytes_q)
                    state_d = DONE;
            end
            WRITE: begin
                out_ram_addr = cur_addr;
                if (io_stall) begin
                    state_d = IO_WAIT;
                end else begin
                    out_ram_wr   = ena;
                    out_ram_dout = wshift[7:0];
                    if (cnt_q == nbytes_q - 3'd1)
                        state_d = DONE;
                end
            end
            IO_WAIT: begin
                if (!in_io_full)
                    state_d = WRITE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            base_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            nbytes_q     <= '0;
            is_fetch_q   <= 1'b0;
            is_write_q   <= 1'b0;
            streak_q     <= '0;
            mask_q       <= '0;
            fetch_data_q <= '0;
            ls_data_q    <= '0;
        end else if (ena) begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    mask_q <= 2'b00;
                    if (grant_fetch || grant_ls) begin
                        base_q     <= grant_fetch ? in_fetch_addr : in_ls_addr;
                        wdata_q    <= in_ls_data;
                        cnt_q      <= '0;
                        nbytes_q   <= grant_fetch ? 3'd4 : ls_nbytes;
                        is_fetch_q <= grant_fetch;
                        is_write_q <= grant_ls && in_ls_iswrite;
                        if (grant_fetch) begin
                            streak_q     <= '0;
                            fetch_data_q <= '0;
                        end else begin
                            if (streak_q < SW'(FETCH_STARVE_LIMIT))
                                streak_q <= streak_q + 1'b1;
                            if (!in_ls_iswrite)
                                ls_data_q <= '0;
                        end
                    end
                end
                READ: begin
                    if (!in_clear) begin
                        cnt_q <= cnt_q + 3'd1;
                        // RAM returns byte k one cycle after its address.
                        if (cnt_q != 3'd0) begin
                            if (is_fetch_q)
                                fetch_data_q[{cap_idx, 3'b000} +: 8] <= in_ram_din;
                            else
                                ls_data_q[{cap_idx, 3'b000} +: 8] <= in_ram_din;
                        end
                    end
                end
                WRITE: begin
                    if (!io_stall)
                        cnt_q <= cnt_q + 3'd1;
                end
                DONE:    mask_q <= is_fetch_q ? 2'b01 : 2'b10;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte RAM model, ok-pulse scoreboard and
// cycle-exact pin checks for fetch, store, starvation, IO stall, flush, reset and ena.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n, ena, in_clear;
    logic        in_fetch_req;
    logic [31:0] in_fetch_addr;
    logic        out_fetch_ok;
    logic [31:0] out_fetch_data;
    logic        in_ls_req, in_ls_iswrite;
    logic [1:0]  in_ls_size;
    logic [31:0] in_ls_addr, in_ls_data;
    logic        out_ls_ok;
    logic [31:0] out_ls_data;
    logic [31:0] out_ram_addr;
    logic        out_ram_wr;
    logic [7:0]  out_ram_dout;
    logic [7:0]  in_ram_din = 8'h00;
    logic        in_io_full;

    mem_arbiter #(.FETCH_STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_clear(in_clear),
        .in_fetch_req(in_fetch_req), .in_fetch_addr(in_fetch_addr),
        .out_fetch_ok(out_fetch_ok), .out_fetch_data(out_fetch_data),
        .in_ls_req(in_ls_req), .in_ls_iswrite(in_ls_iswrite), .in_ls_size(in_ls_size),
        .in_ls_addr(in_ls_addr), .in_ls_data(in_ls_data),
        .out_ls_ok(out_ls_ok), .out_ls_data(out_ls_data),
        .out_ram_addr(out_ram_addr), .out_ram_wr(out_ram_wr), .out_ram_dout(out_ram_dout),
        .in_ram_din(in_ram_din), .in_io_full(in_io_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_fetch;
        bit          chk;
        logic [31:0] data;
    } sb_t;
    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    sb_t         sb[$];
    wr_t         wlog[$];
    sb_t         mon_e;
    logic [7:0]  mem [logic [31:0]];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte RAM: one-cycle read latency, writes logged for duplicate detection.
    always @(posedge clk) begin
        in_ram_din <= mem.exists(out_ram_addr) ? mem[out_ram_addr] : 8'h00;
        if (out_ram_wr) begin
            mem[out_ram_addr] = out_ram_dout;
            wlog.push_back('{a: out_ram_addr, d: out_ram_dout});
        end
    end

    always @(negedge clk) begin
        if (rst_n && (out_fetch_ok || out_ls_ok)) begin
            if (sb.size() == 0) begin
                check("unexpected_ok", {30'd0, out_fetch_ok, out_ls_ok}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ok_kind", {31'd0, out_fetch_ok}, {31'd0, mon_e.is_fetch});
                if (mon_e.chk)
                    check(mon_e.is_fetch ? "fetch_data" : "ls_data",
                          mon_e.is_fetch ? out_fetch_data : out_ls_data, mon_e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wait_ok(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            seen = out_fetch_ok || out_ls_ok;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic ls_start(input bit wr, input logic [1:0] size, input logic [31:0] a,
                            input logic [31:0] d);
        in_ls_req = 1'b1; in_ls_iswrite = wr; in_ls_size = size;
        in_ls_addr = a; in_ls_data = d;
    endtask

    initial begin
        int got;
        rst_n = 1'b0; ena = 1'b1; in_clear = 1'b0; in_io_full = 1'b0;
        in_fetch_req = 1'b0; in_fetch_addr = '0;
        in_ls_req = 1'b0; in_ls_iswrite = 1'b0; in_ls_size = '0;
        in_ls_addr = '0; in_ls_data = '0;
        mem[32'h100] = 8'h13; mem[32'h101] = 8'h00; mem[32'h102] = 8'h00; mem[32'h103] = 8'h00;
        mem[32'h400] = 8'h11; mem[32'h401] = 8'h22; mem[32'h402] = 8'h33; mem[32'h403] = 8'h44;
        idle(3);
        check("rst_addr", out_ram_addr, 32'd0);
        check("rst_wr_ok", {29'd0, out_ram_wr, out_fetch_ok, out_ls_ok}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Store word 0xAABBCCDD to 0x200: bytes DD,CC,BB,AA on C0..C3, ok at C4.
        sb.push_back('{is_fetch: 1'b0, chk: 1'b0, data: 32'd0});
        ls_start(1'b1, 2'd2, 32'h200, 32'hAABB_CCDD);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] wd;
            wd = 32'hAABB_CCDD;
            step();
            check("t2_wr", {31'd0, out_ram_wr}, 32'd1);
            check("t2_addr", out_ram_addr, 32'h200 + k);
            check("t2_dout", {24'd0, out_ram_dout}, {24'd0, wd[8*k +: 8]});
        end
        step();
        check("t2_ok", {31'd0, out_ls_ok}, 32'd1);
        in_ls_req = 1'b0;
        check("t2_mem", {24'd0, mem[32'h203]}, 32'h0000_00AA);
        idle(3);

        // Fetch 0x100: addresses on C0..C3, ok at C5 with 0x00000013.
        sb.push_back('{is_fetch: 1'b1, chk: 1'b1, data: 32'h0000_0013});
        in_fetch_req = 1'b1; in_fetch_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t1_addr", out_ram_addr, 32'h100 + k);
            check("t1_wr", {31'd0, out_ram_wr}, 32'd0);
        end
        step();
        check("t1_early_ok", {31'd0, out_fetch_ok}, 32'd0);
        step();
        check("t1_ok", {31'd0, out_fetch_ok}, 32'd1);
        in_fetch_req = 1'b0;
        idle(3);

        // Both held: grant order L,L,L,L,F,L,L,L,L,F.
        for (int g = 0; g < 10; g++) begin
            if (g == 4 || g == 9)
                sb.push_back('{is_fetch: 1'b1, chk: 1'b1, data: 32'h0000_0013});
            else
                sb.push_back('{is_fetch: 1'b0, chk: 1'b1, data: 32'h4433_2211});
        end
        in_fetch_req = 1'b1; in_fetch_addr = 32'h100;
        ls_start(1'b0, 2'd2, 32'h400, 32'd0);
        got = 0;
        for (int i = 0; i < 400 && got < 10; i++) begin
            step();
            if (out_fetch_ok || out_ls_ok) got++;
        end
        in_fetch_req = 1'b0; in_ls_req = 1'b0;
        check("t3_ok_count", got, 32'd10);
        idle(3);

        // IO byte store 0x41 to 0x30000, io_full high for 3 cycles from the request.
        sb.push_back('{is_fetch: 1'b0, chk: 1'b0, data: 32'd0});
        ls_start(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041);
        in_io_full = 1'b1;
        step();
        check("t4_wr_c0", {31'd0, out_ram_wr}, 32'd0);
        step();
        check("t4_wr_c1", {31'd0, out_ram_wr}, 32'd0);
        step();
        in_io_full = 1'b0;
        check("t4_wr_c2", {31'd0, out_ram_wr}, 32'd0);
        step();
        check("t4_wr_c3", {31'd0, out_ram_wr}, 32'd1);
        check("t4_dout", {24'd0, out_ram_dout}, 32'h41);
        check("t4_addr", out_ram_addr, 32'h0003_0000);
        step();
        check("t4_ok", {31'd0, out_ls_ok}, 32'd1);
        in_ls_req = 1'b0;
        idle(3);

        // Flush at C2 of a load word: back to IDLE at C3, no ok ever.
        ls_start(1'b0, 2'd2, 32'h400, 32'd0);
        idle(3);
        in_clear = 1'b1; in_ls_req = 1'b0;
        step();
        in_clear = 1'b0;
        check("t5_idle_addr", out_ram_addr, 32'd0);
        check("t5_no_ok", {31'd0, out_ls_ok}, 32'd0);
        idle(6);

        // Flush at C1 of a store word: store completes, ok at C4.
        sb.push_back('{is_fetch: 1'b0, chk: 1'b0, data: 32'd0});
        ls_start(1'b1, 2'd2, 32'h200, 32'h0102_0304);
        idle(2);
        in_clear = 1'b1;
        check("t5s_wr_c1", {31'd0, out_ram_wr}, 32'd1);
        step();
        in_clear = 1'b0;
        check("t5s_addr_c2", out_ram_addr, 32'h202);
        idle(2);
        check("t5s_ok", {31'd0, out_ls_ok}, 32'd1);
        in_ls_req = 1'b0;
        idle(3);

        // Reset mid-read clears every output.
        in_fetch_req = 1'b1; in_fetch_addr = 32'h100;
        idle(3);
        rst_n = 1'b0; in_fetch_req = 1'b0;
        step();
        check("t6_rst_addr", out_ram_addr, 32'd0);
        check("t6_rst_flags", {28'd0, out_ram_wr, out_ram_dout != 8'd0, out_fetch_ok, out_ls_ok},
              32'd0);
        check("t6_rst_fdata", out_fetch_data, 32'd0);
        check("t6_rst_ldata", out_ls_data, 32'd0);
        rst_n = 1'b1;
        idle(3);

        // ena low for 2 cycles mid-store: write resumes at byte 1, no duplicates.
        wlog.delete();
        sb.push_back('{is_fetch: 1'b0, chk: 1'b0, data: 32'd0});
        ls_start(1'b1, 2'd2, 32'h500, 32'h5566_7788);
        step();
        check("t6_c0_addr", out_ram_addr, 32'h500);
        step();
        ena = 1'b0;
        #1;
        check("t6_ena_wr0", {31'd0, out_ram_wr}, 32'd0);
        step();
        check("t6_ena_wr1", {31'd0, out_ram_wr}, 32'd0);
        step();
        ena = 1'b1;
        #1;
        check("t6_resume_addr", out_ram_addr, 32'h501);
        check("t6_resume_dout", {24'd0, out_ram_dout}, 32'h77);
        wait_ok("t6_ok_timeout", 10);
        in_ls_req = 1'b0;
        idle(2);
        check("t6_wlog_len", wlog.size(), 32'd4);
        for (int k = 0; k < wlog.size() && k < 4; k++) begin
            logic [31:0] wd;
            wd = 32'h5566_7788;
            check("t6_wlog_addr", wlog[k].a, 32'h500 + k);
            check("t6_wlog_data", {24'd0, wlog[k].d}, {24'd0, wd[8*k +: 8]});
        end

        idle(4);
        check("sb_drain", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
